// File: rtl/dyn_bin_pingpong.sv
// -----------------------------------------------------------------------------
// dyn_bin_pingpong
//   Frame-buffered binarizer. Captures one grayscale frame, tracks its maximum,
//   derives a threshold (RATIO_NUM/256 of the max, or a static value) at frame
//   close, then streams one bit per pixel: (pixel > thr) XOR INVERT.
//
//   Build option: define BIN_PINGPONG_EN for two frame banks, so capture of
//   frame N+1 overlaps emission of frame N. Undefined: a single bank, and
//   input is stalled from frame close until the frame has been emitted.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   frame_start         one-cycle pulse, restarts the input frame
//   pix_in[_valid]      grayscale pixel stream in
//   pix_in_ready        input can be accepted this cycle
//   thr_mode            0 = dynamic, 1 = static (sampled at frame close)
//   static_thr          static threshold (sampled at frame close)
//   pix_out[_valid]     binarized pixel stream out
//   pix_out_ready       downstream accepts pix_out
//   pix_out_last        marks the final pixel of the output frame
//   frame_done          pulse in the cycle after the last pixel is accepted
//   frame_max           maximum of the most recently closed frame
//   frame_thr           threshold of the frame being emitted
// -----------------------------------------------------------------------------
module dyn_bin_pingpong #(
   parameter int PIX_W     = 8,
   parameter int IMG_W     = 28,
   parameter int IMG_H     = 28,
   parameter int RATIO_NUM = 77,
   parameter int INVERT    = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_in_valid,
   output logic             pix_in_ready,
   input  logic             thr_mode,
   input  logic [PIX_W-1:0] static_thr,
   output logic             pix_out,
   output logic             pix_out_valid,
   input  logic             pix_out_ready,
   output logic             pix_out_last,
   output logic             frame_done,
   output logic [PIX_W-1:0] frame_max,
   output logic [PIX_W-1:0] frame_thr
);

   localparam int               N        = IMG_W * IMG_H;
   localparam int               CNT_W    = $clog2(N);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
   localparam logic [PIX_W+7:0] RATIO    = (PIX_W + 8)'(RATIO_NUM);
   localparam logic             INV      = (INVERT != 0);
`ifdef BIN_PINGPONG_EN
   localparam int               AW       = CNT_W + 1;   // {bank, pixel index}
`else
   localparam int               AW       = CNT_W;
`endif
   localparam int               DEPTH    = 2 ** AW;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} rd_state_t;

   logic [PIX_W-1:0] mem [DEPTH];
   logic             wr_bank, rd_bank;
   logic [1:0]       full, full_nxt;
   logic [PIX_W-1:0] thr_bank [2];
   logic [CNT_W-1:0] wr_cnt, cnt_eff, rd_cnt;
   logic [PIX_W-1:0] run_max, max_eff, new_max, new_thr;
   logic [PIX_W+7:0] prod;
   logic [AW-1:0]    wr_addr, rd_addr;
   logic             rst_done, in_xfer, fs, close, rel;

   rd_state_t        state;
   logic             rd_en, rd_vld, rd_last, rd_bit, pop;
   logic [PIX_W-1:0] rd_pix;
   logic             skid_vld, skid_bit, skid_last;

   // ---------------------------------------------------------------- capture
   // rst_done keeps pix_in_ready low while reset is applied.
   assign pix_in_ready = rst_done & ~full[wr_bank];
   assign in_xfer      = pix_in_valid & pix_in_ready;
   assign fs           = frame_start & pix_in_ready;

   // NOTE: every variable gets a value on every path through always_comb,
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      cnt_eff  = fs ? '0 : wr_cnt;          // frame_start makes this pixel 0
      max_eff  = fs ? '0 : run_max;
      new_max  = (pix_in > max_eff) ? pix_in : max_eff;
      prod     = (PIX_W + 8)'(new_max) * RATIO;
      new_thr  = thr_mode ? static_thr : PIX_W'(prod >> 8);
      close    = in_xfer && (cnt_eff == LAST_IDX);
      full_nxt = full;
      if (rel)   full_nxt[rd_bank] = 1'b0;
      if (close) full_nxt[wr_bank] = 1'b1;
   end

`ifdef BIN_PINGPONG_EN
   // Move the writer to the other bank as soon as its own is full and the
   // other is free; banks are filled and drained in strict alternation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
      end else begin
         if (full_nxt[wr_bank] && !full_nxt[~wr_bank]) wr_bank <= ~wr_bank;
         if (rel) rd_bank <= ~rd_bank;
      end
   end
   assign wr_addr = {wr_bank, cnt_eff};
   assign rd_addr = {rd_bank, rd_cnt};
`else
   assign wr_bank = 1'b0;
   assign rd_bank = 1'b0;
   assign wr_addr = cnt_eff;
   assign rd_addr = rd_cnt;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_done    <= 1'b0;
         full        <= '0;
         wr_cnt      <= '0;
         run_max     <= '0;
         frame_max   <= '0;
         thr_bank[0] <= '0;
         thr_bank[1] <= '0;
      end else begin
         rst_done <= 1'b1;
         full     <= full_nxt;
         if (in_xfer) begin
            if (close) begin
               wr_cnt            <= '0;
               run_max           <= '0;
               frame_max         <= new_max;
               thr_bank[wr_bank] <= new_thr;
            end else begin
               wr_cnt  <= cnt_eff + 1'b1;
               run_max <= new_max;
            end
         end else if (fs) begin
            wr_cnt  <= '0;
            run_max <= '0;
         end
      end
   end

   // NOTE: the frame store has no reset; stale contents are never read
   // because a bank is only streamed after a complete frame was written.
   always_ff @(posedge clk) begin
      if (in_xfer) mem[wr_addr] <= pix_in;
      if (rd_en)   rd_pix       <= mem[rd_addr];
   end

   // ------------------------------------------------------------------ emit
   // Output stage: the registered memory read plus one skid entry. A read is
   // issued only while the skid entry is empty, so a read landing in a stall
   // always has somewhere to go and rd_en never depends on pix_out_ready.
   assign rd_en  = ((state == S_LOAD) || (state == S_STREAM)) && !skid_vld;
   assign rd_bit = (rd_pix > frame_thr) ^ INV;
   assign rel    = (state == S_DRAIN) && !rd_vld && !skid_vld;

   assign pix_out_valid = rd_vld | skid_vld;
   assign pix_out       = skid_vld ? skid_bit  : (rd_vld & rd_bit);
   assign pix_out_last  = skid_vld ? skid_last : (rd_vld & rd_last);
   assign pop           = pix_out_valid & pix_out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         rd_cnt     <= '0;
         frame_thr  <= '0;
         rd_vld     <= 1'b0;
         rd_last    <= 1'b0;
         skid_vld   <= 1'b0;
         skid_bit   <= 1'b0;
         skid_last  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= pop & pix_out_last;

         // Park the current head in the skid entry when it is stalled and a
         // new read is about to overwrite the memory register.
         if (skid_vld) begin
            if (pix_out_ready) skid_vld <= 1'b0;
         end else if (rd_vld && rd_en && !pix_out_ready) begin
            skid_vld  <= 1'b1;
            skid_bit  <= rd_bit;
            skid_last <= rd_last;
         end

         if (rd_en) begin
            rd_vld  <= 1'b1;
            rd_last <= (rd_cnt == LAST_IDX);
         end else if (!skid_vld && pix_out_ready) begin
            rd_vld  <= 1'b0;
         end

         case (state)
            S_IDLE:   if (full[rd_bank]) state <= S_LOAD;
            S_LOAD, S_STREAM: begin
               // Pixel 0 is read in the LOAD cycle so it meets frame_thr
               // one cycle later, together with the first output.
               if (state == S_LOAD) frame_thr <= thr_bank[rd_bank];
               if (rd_en) begin
                  if (rd_cnt == LAST_IDX) begin
                     rd_cnt <= '0;
                     state  <= S_DRAIN;
                  end else begin
                     rd_cnt <= rd_cnt + 1'b1;
                     state  <= S_STREAM;
                  end
               end
            end
            S_DRAIN:  if (rel) state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dyn_bin_pingpong.sv
// -----------------------------------------------------------------------------
// tb_dyn_bin_pingpong
//   Directed bench for dyn_bin_pingpong at 28x28, RATIO_NUM=77, INVERT=0.
//   Covers reset state, dynamic and static thresholds, latency, backpressure,
//   back-to-back frames, mid-frame restart and reset during streaming.
// -----------------------------------------------------------------------------
module tb_dyn_bin_pingpong;

   localparam int PIX_W = 8;
   localparam int N     = 28 * 28;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             frame_start;
   logic [PIX_W-1:0] pix_in;
   logic             pix_in_valid;
   logic             pix_in_ready;
   logic             thr_mode;
   logic [PIX_W-1:0] static_thr;
   logic             pix_out;
   logic             pix_out_valid;
   logic             pix_out_ready;
   logic             pix_out_last;
   logic             frame_done;
   logic [PIX_W-1:0] frame_max;
   logic [PIX_W-1:0] frame_thr;

   dyn_bin_pingpong #(
      .PIX_W(PIX_W), .IMG_W(28), .IMG_H(28), .RATIO_NUM(77), .INVERT(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
      .thr_mode(thr_mode), .static_thr(static_thr),
      .pix_out(pix_out), .pix_out_valid(pix_out_valid),
      .pix_out_ready(pix_out_ready), .pix_out_last(pix_out_last),
      .frame_done(frame_done), .frame_max(frame_max), .frame_thr(frame_thr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int rdy_mode = 0;       // 0 = always ready, 1 = random ready
   int stall_cnt;
   int last_in_cyc;
   int stall_err = 0;

   logic [1:0] out_q[$];   // {last, bit} per accepted output
   int         out_cyc_q[$];
   int         done_q[$];
   bit         exp_q[$];
   logic       prev_stall = 1'b0;
   logic       prev_bit, prev_last;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Output monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!pix_out_valid || pix_out !== prev_bit || pix_out_last !== prev_last))
            stall_err++;
         if (pix_out_valid && pix_out_ready) begin
            out_q.push_back({pix_out_last, pix_out});
            out_cyc_q.push_back(cyc);
         end
         if (frame_done) done_q.push_back(cyc);
         prev_stall = pix_out_valid && !pix_out_ready;
         prev_bit   = pix_out;
         prev_last  = pix_out_last;
      end
   end

   // Downstream ready driver.
   initial begin
      pix_out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) pix_out_ready = 1'b1;
         else               pix_out_ready = ($urandom_range(0, 1) == 1);
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [7:0] pix_val(input int kind, input int k);
      case (kind)
         0:       return 8'(k % 200);
         1:       return 8'(k % 256);
         2:       return 8'((k * 37 + 11) % 251);
         3:       return 8'((k * 13) % 240);
         4:       return 8'd250;
         default: return 8'(k % 100);
      endcase
   endfunction

   task automatic add_expected(input int kind, input bit mode, input int sthr);
      int mx = 0;
      int thr;
      for (int k = 0; k < N; k++) if (int'(pix_val(kind, k)) > mx) mx = int'(pix_val(kind, k));
      thr = mode ? sthr : ((mx * 77) >> 8);
      for (int k = 0; k < N; k++) exp_q.push_back(int'(pix_val(kind, k)) > thr);
   endtask

   task automatic send_frame(input int kind, input int cnt, input bit with_start);
      for (int k = 0; k < cnt; k++) begin
         int guard = 0;
         pix_in       = pix_val(kind, k);
         pix_in_valid = 1'b1;
         frame_start  = with_start && (k == 0);
         while (!pix_in_ready && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
            stall_cnt++;
         end
         if (guard >= 5000) begin
            check("in_ready_timeout", 0, 1);
            break;
         end
         last_in_cyc = cyc;
         @(posedge clk);
         #1;
      end
      pix_in_valid = 1'b0;
      frame_start  = 1'b0;
   endtask

   task automatic wait_outputs(input int n, input int budget);
      int g = 0;
      while (out_q.size() < n && g < budget) begin
         @(posedge clk);
         #1;
         g++;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic compare_outputs(input string tag);
      int bad_bit  = 0;
      int bad_last = 0;
      check({tag, "_count"}, out_q.size(), exp_q.size());
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
         if (out_q[i][0] !== exp_q[i]) bad_bit++;
         if (out_q[i][1] !== ((i % N) == N - 1)) bad_last++;
      end
      check({tag, "_bits"}, bad_bit, 0);
      check({tag, "_last"}, bad_last, 0);
   endtask

   task automatic clear_queues();
      out_q.delete();
      out_cyc_q.delete();
      done_q.delete();
      exp_q.delete();
      stall_err = 0;
   endtask

   initial begin
      logic b128, b129;
      int   stall_b, stall_c;

      rst_n        = 1'b0;
      frame_start  = 1'b0;
      pix_in       = '0;
      pix_in_valid = 1'b0;
      thr_mode     = 1'b0;
      static_thr   = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            {pix_out_valid, pix_out, pix_out_last, frame_done, pix_in_ready, frame_max, frame_thr}, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("ready_after_reset", pix_in_ready, 1);

      // Dynamic ramp k%200: max 199, thr (199*77)>>8 = 59
      clear_queues();
      add_expected(0, 1'b0, 0);
      send_frame(0, N, 1'b1);
      check("ramp_max", frame_max, 199);
`ifdef BIN_PINGPONG_EN
      check("ramp_ready_after_close", pix_in_ready, 1);
`else
      check("ramp_ready_after_close", pix_in_ready, 0);
`endif
      wait_outputs(N, 3000);
      check("ramp_thr", frame_thr, 59);
      check("ramp_latency", out_cyc_q[0] - last_in_cyc, 3);
      check("ramp_rate", out_cyc_q[$] - out_cyc_q[0], N - 1);
      check("ramp_done_count", done_q.size(), 1);
      check("ramp_done_cycle", done_q[0], out_cyc_q[$] + 1);
      check("ramp_ready_after_done", pix_in_ready, 1);
      compare_outputs("ramp");

      // Static threshold 128: pixel 128 -> 0, pixel 129 -> 1
      clear_queues();
      thr_mode   = 1'b1;
      static_thr = 8'd128;
      add_expected(1, 1'b1, 128);
      send_frame(1, N, 1'b1);
      wait_outputs(N, 3000);
      thr_mode = 1'b0;
      check("static_thr", frame_thr, 128);
      check("static_max", frame_max, 255);
      b128 = (out_q.size() > 129) ? out_q[128][0] : 1'bx;
      b129 = (out_q.size() > 129) ? out_q[129][0] : 1'bx;
      check("static_pix128", b128, 0);
      check("static_pix129", b129, 1);
      compare_outputs("static");

      // Random backpressure
      clear_queues();
      rdy_mode = 1;
      add_expected(2, 1'b0, 0);
      send_frame(2, N, 1'b1);
      wait_outputs(N, 8000);
      rdy_mode = 0;
      check("bp_stable", stall_err, 0);
      check("bp_done_count", done_q.size(), 1);
      check("bp_thr", frame_thr, 75);
      compare_outputs("bp");

      // Three frames back-to-back, second and third without frame_start
      clear_queues();
      add_expected(3, 1'b0, 0);
      add_expected(2, 1'b0, 0);
      add_expected(0, 1'b0, 0);
      send_frame(3, N, 1'b1);
      stall_cnt = 0;
      send_frame(2, N, 1'b0);
      stall_b = stall_cnt;
      stall_cnt = 0;
      send_frame(0, N, 1'b0);
      stall_c = stall_cnt;
`ifdef BIN_PINGPONG_EN
      check("pp_stall_frame2", stall_b, 0);
      check("pp_stall_frame3", stall_c, 3);
`else
      check("pp_stall_frame2", stall_b, 787);
      check("pp_stall_frame3", stall_c, 787);
`endif
      wait_outputs(3 * N, 8000);
      check("pp_done_count", done_q.size(), 3);
      compare_outputs("pp");

      // Restart after 300 pixels: only the following frame is emitted
      clear_queues();
      add_expected(5, 1'b0, 0);
      send_frame(4, 300, 1'b1);
      send_frame(5, N, 1'b1);
      check("restart_max", frame_max, 99);
      wait_outputs(N, 3000);
      repeat (50) @(posedge clk);
      #1;
      check("restart_thr", frame_thr, 29);
      check("restart_done_count", done_q.size(), 1);
      compare_outputs("restart");

      // Reset while streaming, then a clean frame
      clear_queues();
      send_frame(0, N, 1'b1);
      wait_outputs(100, 3000);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_outputs",
            {pix_out_valid, pix_out, pix_out_last, frame_done, pix_in_ready, frame_max, frame_thr}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      clear_queues();
      add_expected(3, 1'b0, 0);
      send_frame(3, N, 1'b1);
      check("postreset_max", frame_max, 239);
      wait_outputs(N, 3000);
      check("postreset_thr", frame_thr, 71);
      check("postreset_latency", out_cyc_q[0] - last_in_cyc, 3);
      compare_outputs("postreset");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/dyn_bin_pingpong.md
# dyn_bin_pingpong

Parametrised dynamic-threshold binarizer for the preprocessing path, between the grayscale pixel source and the feature/classifier stage. It buffers one frame, tracks its maximum, and derives a threshold as a programmable fraction of that maximum, or takes a static threshold. It then streams one bit per pixel downstream under a valid/ready handshake. Two frame banks let frame N+1 be captured while frame N is emitted.

## Interface
Parameters:
- PIX_W, 8, input pixel width (4..12)
- IMG_W, 28, frame width in pixels
- IMG_H, 28, frame height; frame size N = IMG_W*IMG_H
- RATIO_NUM, 77, threshold ratio numerator over 256 (0..255)
- INVERT, 0, 1 = output bit is inverted (dark-on-light sources)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse, opens a new input frame
- pix_in  in  PIX_W  grayscale pixel
- pix_in_valid  in  1  pix_in qualifier
- pix_in_ready  out  1  block can accept pix_in this cycle
- thr_mode  in  1  0 = dynamic, 1 = static; sampled at frame close
- static_thr  in  PIX_W  static threshold; sampled at frame close
- pix_out  out  1  binarized pixel
- pix_out_valid  out  1  pix_out qualifier
- pix_out_ready  in  1  downstream accepts pix_out
- pix_out_last  out  1  marks pixel N-1 of the output frame
- frame_done  out  1  one-cycle pulse on acceptance of the last output pixel
- frame_max  out  PIX_W  max of the most recently closed frame
- frame_thr  out  PIX_W  threshold applied to the frame being emitted

## Operation
- Input transfer is pix_in_valid & pix_in_ready. Pixels are written to the write bank at wr_cnt (0..N-1), and the running max is updated.
- frame_start clears wr_cnt and the running max. If frame_start and a transfer occur together, that pixel is pixel 0 of the new frame.
- frame_start mid-frame discards the partial frame. It reuses the same bank, and no output is produced for the partial frame.
- Frame close occurs on the transfer with wr_cnt = N-1. Closing does the following:
  - latches the max into frame_max;
  - computes thr = thr_mode ? static_thr : (max*RATIO_NUM)>>8. The product is PIX_W+8 bits wide and the result is truncated to PIX_W, which cannot overflow;
  - marks the bank full and swaps the write bank if the other bank is free.
- Pixels arriving without a preceding frame_start are accepted and counted as a continuation of the open frame.
- Reader states:
  - IDLE: waits for a full bank, then goes to LOAD.
  - LOAD: loads frame_thr for that bank, then goes to STREAM.
  - STREAM: issues reads rd_cnt 0..N-1; pix_out = (pixel > frame_thr) XOR INVERT, a strict comparison.
  - DRAIN: entered after the last read; goes to IDLE once the output stage is empty, freeing the bank.
- The output stage is a 2-entry skid buffer over the registered BRAM read.
  - pix_out, pix_out_last and pix_out_valid hold stable while valid & !ready.
  - Sustained rate is 1 pixel/cycle while ready stays high.
- pix_in_ready is low only when the write bank is full and the read bank is still in use.

## Timing
- All outputs reset to 0. Reset also:
  - clears both banks' full flags, wr_cnt, rd_cnt and the max;
  - returns the reader to IDLE.
- Reset mid-frame drops all buffered data. Buffer contents need no clearing.
- Latency: last input transfer at cycle T gives thr ready at T+1, first read at T+2, and first pix_out_valid at T+3 when the reader is idle.
- frame_done is asserted in the cycle after the pix_out_last transfer.
- max = 0 in dynamic mode gives thr = 0, so only nonzero pixels output 1. RATIO_NUM = 0 behaves the same way.
- Counters hold N-1 maximum and wrap to 0 at close. They are clog2(N) bits wide.

## Configuration
- BIN_PINGPONG_EN defined:
  - two banks of N×PIX_W each;
  - capture overlaps emission.
- BIN_PINGPONG_EN undefined:
  - one bank;
  - pix_in_ready is low from frame close until the cycle after frame_done;
  - frame_start arriving while pix_in_ready is low is ignored.
- Interface and latencies are identical in both builds.

## Test plan
- Static frame check:
  - stimulus: dynamic mode, N=784, pixels ramp k%200, ready held high;
  - response: frame_max=199, thr=(199*77)>>8=59, pix_out=1 exactly for pixels 60..199 mod ramp, first valid 3 cycles after the last input, frame_done after 784 outputs.
- Static mode: static_thr=128, pixel 128 gives 0 and pixel 129 gives 1. INVERT=1 build gives the complement.
- Backpressure: pix_out_ready toggles 1-0-0-1 randomly. Response: no pixel lost or duplicated, outputs stable while stalled, 784 transfers, pix_out_last only on the final one.
- Ping-pong:
  - stimulus: second frame streamed back-to-back during emission of the first;
  - PINGPONG_EN response: pix_in_ready stays high for frame 2 and drops during frame 3 until bank 0 is released;
  - without PINGPONG_EN: ready is low through the frame-1 output.
- Restart and reset:
  - frame_start after 300 pixels: the partial frame produces no output and the next 784 pixels form one frame with a fresh max;
  - rst_n low mid-STREAM: all outputs are 0 immediately, and the next full frame is processed correctly.
